// File: rtl/fp_pkg.sv
// ============================================================================
//  Module      : fp_pkg
//  Description : Shared constants and helpers for the floating-point shifter.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package fp_pkg;

    // Shift direction encoding on the dir port
    localparam logic SHIFT_LEFT  = 1'b0;
    localparam logic SHIFT_RIGHT = 1'b1;

    // Number of register stages for a shifter of 'levels' levels with a
    // register after every 'reg_every' levels: ceil(levels / reg_every).
    // When reg_every is a power of two this reduces to a shift by its log2.
    function automatic int calc_stages(input int levels, input int reg_every);
        if ((reg_every & (reg_every - 1)) == 0)
            return (levels + reg_every - 1) >> $clog2(reg_every);
        return (levels + reg_every - 1) / reg_every;
    endfunction

endpackage : fp_pkg

`default_nettype wire

// File: rtl/fp_shift_level.sv
// ============================================================================
//  Module      : fp_shift_level
//  Description : One combinational level of the log shifter. Shifts by a
//                fixed AMOUNT when enabled and reports the OR of the bits
//                pushed out of the word.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module fp_shift_level
    import fp_pkg::*;
#(
    parameter int DATAWIDTH = 23,
    parameter int AMOUNT    = 1
) (
    input  logic [DATAWIDTH-1:0] value,
    input  logic                 enable,
    input  logic                 dir,
    input  logic                 fill,
    output logic [DATAWIDTH-1:0] shifted,
    output logic                 lost
);

    generate
        if (AMOUNT >= DATAWIDTH) begin : g_saturate
            // Whole word leaves: result is all fill bits, every bit is lost
            always_comb begin
                shifted = value;
                lost    = 1'b0;
                if (enable) begin
                    shifted = (dir == SHIFT_RIGHT) ? {DATAWIDTH{fill}} : '0;
                    lost    = |value;
                end
            end
        end else begin : g_partial
            localparam logic [DATAWIDTH-1:0] c_ones      = '1;
            // Bits that leave through the bottom on a right shift
            localparam logic [DATAWIDTH-1:0] c_low_mask  = ~(c_ones << AMOUNT);
            // Bits that leave through the top on a left shift; also the
            // vacated positions that take the fill on a right shift
            localparam logic [DATAWIDTH-1:0] c_high_mask = ~(c_ones >> AMOUNT);

            // Fixed-distance shift plus lost-bit detection
            always_comb begin
                shifted = value;
                lost    = 1'b0;
                if (enable) begin
                    if (dir == SHIFT_RIGHT) begin
                        shifted = (value >> AMOUNT) | (fill ? c_high_mask : '0);
                        lost    = |(value & c_low_mask);
                    end else begin
                        shifted = value << AMOUNT;
                        lost    = |(value & c_high_mask);
                    end
                end
            end
        end
    endgenerate

endmodule : fp_shift_level

`default_nettype wire

// File: rtl/fp_shift_pipe.sv
// ============================================================================
//  Module      : fp_shift_pipe
//  Description : Pipelined bidirectional barrel shifter with arithmetic mode,
//                sticky/overflow flag, tag passthrough and valid/ready flow
//                control. Levels are applied LSB-first; a register stage
//                follows every REG_EVERY levels, the last one drives outputs.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module fp_shift_pipe
    import fp_pkg::*;
#(
    parameter int DATAWIDTH  = 23,
    parameter int SHIFTWIDTH = 8,
    parameter int REG_EVERY  = 2,
    parameter int TAGWIDTH   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATAWIDTH-1:0]  val,
    input  logic [SHIFTWIDTH-1:0] count,
    input  logic                  dir,
    input  logic                  arith,
    input  logic [TAGWIDTH-1:0]   tag,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATAWIDTH-1:0]  val_o,
    output logic                  sticky_o,
    output logic                  ovf_o,
    output logic [TAGWIDTH-1:0]   tag_o
);

    localparam int P = calc_stages(SHIFTWIDTH, REG_EVERY);

    // Stage registers
    logic                  r_vld   [P];
    logic [DATAWIDTH-1:0]  r_val   [P];
    logic [SHIFTWIDTH-1:0] r_cnt   [P];
    logic                  r_dir   [P];
    logic                  r_arith [P];
    logic                  r_sign  [P];
    logic                  r_flag  [P];
    logic [TAGWIDTH-1:0]   r_tag   [P];

    // What feeds each stage: the input ports for stage 0, else the stage before
    logic                  w_src_vld   [P];
    logic [DATAWIDTH-1:0]  w_src_val   [P];
    logic [SHIFTWIDTH-1:0] w_src_cnt   [P];
    logic                  w_src_dir   [P];
    logic                  w_src_arith [P];
    logic                  w_src_sign  [P];
    logic                  w_src_flag  [P];
    logic [TAGWIDTH-1:0]   w_src_tag   [P];
    logic                  w_adv       [P];

    // Per-level datapath chain
    logic [DATAWIDTH-1:0]  w_lvi  [SHIFTWIDTH];
    logic [DATAWIDTH-1:0]  w_lvo  [SHIFTWIDTH];
    logic                  w_lfi  [SHIFTWIDTH];
    logic                  w_lfo  [SHIFTWIDTH];
    logic                  w_lost [SHIFTWIDTH];

    genvar s, k;

    generate
        for (s = 0; s < P; s++) begin : g_src
            if (s == 0) begin : g_from_input
                assign w_src_vld[s]   = in_valid;
                assign w_src_val[s]   = val;
                assign w_src_cnt[s]   = count;
                assign w_src_dir[s]   = dir;
                assign w_src_arith[s] = arith;
                assign w_src_sign[s]  = val[DATAWIDTH-1];
                assign w_src_flag[s]  = 1'b0;
                assign w_src_tag[s]   = tag;
            end else begin : g_from_stage
                assign w_src_vld[s]   = r_vld[s-1];
                assign w_src_val[s]   = r_val[s-1];
                assign w_src_cnt[s]   = r_cnt[s-1];
                assign w_src_dir[s]   = r_dir[s-1];
                assign w_src_arith[s] = r_arith[s-1];
                assign w_src_sign[s]  = r_sign[s-1];
                assign w_src_flag[s]  = r_flag[s-1];
                assign w_src_tag[s]   = r_tag[s-1];
            end

            // Ready ripples back from the output so a full pipe still moves
            // every cycle the consumer takes a result
            if (s == P - 1) begin : g_adv_out
                assign w_adv[s] = !r_vld[s] || out_ready;
            end else begin : g_adv_mid
                assign w_adv[s] = !r_vld[s] || w_adv[s+1];
            end
        end

        for (k = 0; k < SHIFTWIDTH; k++) begin : g_level
            localparam int S = k / REG_EVERY;

            if (k % REG_EVERY == 0) begin : g_head
                assign w_lvi[k] = w_src_val[S];
                assign w_lfi[k] = w_src_flag[S];
            end else begin : g_chain
                assign w_lvi[k] = w_lvo[k-1];
                assign w_lfi[k] = w_lfo[k-1];
            end

            fp_shift_level #(
                .DATAWIDTH (DATAWIDTH),
                .AMOUNT    (1 << k)
            ) u_level (
                .value   (w_lvi[k]),
                .enable  (w_src_cnt[S][k]),
                .dir     (w_src_dir[S]),
                .fill    (w_src_arith[S] & w_src_sign[S]),
                .shifted (w_lvo[k]),
                .lost    (w_lost[k])
            );

            // One running flag serves as sticky or overflow depending on dir
            assign w_lfo[k] = w_lfi[k] | w_lost[k];
        end

        for (s = 0; s < P; s++) begin : g_stage
            localparam int LAST = (((s + 1) * REG_EVERY < SHIFTWIDTH) ?
                                   (s + 1) * REG_EVERY : SHIFTWIDTH) - 1;

            // Capture this stage's levels; payload only moves with a valid op
            // so a stalled or drained output keeps its last result
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_vld[s]   <= 1'b0;
                    r_val[s]   <= '0;
                    r_cnt[s]   <= '0;
                    r_dir[s]   <= 1'b0;
                    r_arith[s] <= 1'b0;
                    r_sign[s]  <= 1'b0;
                    r_flag[s]  <= 1'b0;
                    r_tag[s]   <= '0;
                end else if (w_adv[s]) begin
                    r_vld[s] <= w_src_vld[s];
                    if (w_src_vld[s]) begin
                        r_val[s]   <= w_lvo[LAST];
                        r_cnt[s]   <= w_src_cnt[s];
                        r_dir[s]   <= w_src_dir[s];
                        r_arith[s] <= w_src_arith[s];
                        r_sign[s]  <= w_src_sign[s];
                        r_flag[s]  <= w_lfo[LAST];
                        r_tag[s]   <= w_src_tag[s];
                    end
                end
            end
        end
    endgenerate

    assign in_ready  = w_adv[0];
    assign out_valid = r_vld[P-1];
    assign val_o     = r_val[P-1];
    assign tag_o     = r_tag[P-1];
    assign sticky_o  = r_flag[P-1] & (r_dir[P-1] == SHIFT_RIGHT);
    assign ovf_o     = r_flag[P-1] & (r_dir[P-1] == SHIFT_LEFT);

    // Control fields of the output stage have no consumer downstream
    logic w_unused;
    assign w_unused = ^{r_cnt[P-1], r_arith[P-1], r_sign[P-1]};

endmodule : fp_shift_pipe

`default_nettype wire

// File: tb/tb_fp_shift_pipe.sv
// ============================================================================
//  Module      : tb_fp_shift_pipe
//  Description : Self-checking bench for fp_shift_pipe (scoreboard queue,
//                table vectors, backpressure, reset and random streams).
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_fp_shift_pipe;

    localparam int DW  = 23;
    localparam int SW  = 8;
    localparam int TW  = 4;
    localparam int LAT = 4;
    localparam int NV  = 13;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] val;
    logic [SW-1:0] count;
    logic          dir;
    logic          arith;
    logic [TW-1:0] tag;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] val_o;
    logic          sticky_o;
    logic          ovf_o;
    logic [TW-1:0] tag_o;

    fp_shift_pipe #(
        .DATAWIDTH  (DW),
        .SHIFTWIDTH (SW),
        .REG_EVERY  (2),
        .TAGWIDTH   (TW)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .val       (val),
        .count     (count),
        .dir       (dir),
        .arith     (arith),
        .tag       (tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .val_o     (val_o),
        .sticky_o  (sticky_o),
        .ovf_o     (ovf_o),
        .tag_o     (tag_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DW-1:0] v;
        logic          s;
        logic          o;
        logic [TW-1:0] t;
    } res_t;

    typedef struct {
        logic [DW-1:0] v;
        logic [SW-1:0] c;
        logic          d;
        logic          a;
        logic [DW-1:0] ev;
        logic          es;
        logic          eo;
    } vec_t;

    vec_t tbl [NV];
    res_t exp_q [$];
    res_t pend;
    res_t held;
    logic held_v;
    logic accepted;
    logic seen_out;
    logic saw_block;
    logic rand_rdy;
    int   stall_cnt;
    int   out_count;
    int   n_checks;
    int   n_fail;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: shift into a double-width field and inspect what falls off
    function automatic res_t model(input logic [DW-1:0] v, input logic [SW-1:0] c,
                                   input logic d, input logic a, input logic [TW-1:0] t);
        res_t r;
        logic [2*DW-1:0] ext;
        r = '0;
        r.t = t;
        if (!d) begin
            if (int'(c) >= DW) begin
                r.v = '0;
                r.o = |v;
            end else begin
                ext = {{DW{1'b0}}, v} << c;
                r.v = ext[DW-1:0];
                r.o = |ext[2*DW-1:DW];
            end
        end else begin
            if (int'(c) >= DW) begin
                r.v = a ? {DW{v[DW-1]}} : '0;
                r.s = |v;
            end else begin
                ext = {v, {DW{1'b0}}};
                if (a) ext = $signed(ext) >>> c;
                else   ext = ext >> c;
                r.v = ext[2*DW-1:DW];
                r.s = |ext[DW-1:0];
            end
        end
        return r;
    endfunction

    // One clock cycle: entered just after a falling edge with inputs set
    task automatic tick();
        res_t cur;
        res_t e;
        accepted = 1'b0;
        if (stall_cnt > 0) begin
            out_ready = 1'b0;
            stall_cnt--;
        end else if (rand_rdy) begin
            out_ready = ($urandom_range(0, 3) != 0);
        end else begin
            out_ready = 1'b1;
        end
        #1;
        cur = {val_o, sticky_o, ovf_o, tag_o};
        if (held_v) begin
            check("stall_hold", 64'({out_valid, cur}), 64'({1'b1, held}));
            held_v = 1'b0;
        end
        if (out_valid) begin
            seen_out = 1'b1;
            if (out_ready) begin
                out_count++;
                if (exp_q.size() == 0) begin
                    check("unexpected_output", 64'(out_valid), 64'(0));
                end else begin
                    e = exp_q.pop_front();
                    check("result", 64'(cur), 64'(e));
                end
            end else begin
                held_v = 1'b1;
                held   = cur;
            end
        end
        if (in_valid && !in_ready) saw_block = 1'b1;
        if (in_valid && in_ready) begin
            exp_q.push_back(pend);
            accepted = 1'b1;
        end
        @(negedge clk);
    endtask

    task automatic drive(input logic [DW-1:0] v, input logic [SW-1:0] c, input logic d,
                         input logic a, input logic [TW-1:0] t, input res_t e);
        val = v; count = c; dir = d; arith = a; tag = t; pend = e;
        in_valid = 1'b1;
        for (int n = 0; n < 100; n++) begin
            tick();
            if (accepted) break;
        end
        if (!accepted) check("accept_timeout", 64'(0), 64'(1));
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        in_valid = 1'b0;
        n = 0;
        while (exp_q.size() > 0 && n < 500) begin
            tick();
            n++;
        end
        if (exp_q.size() > 0) begin
            check("drain_timeout", 64'(exp_q.size()), 64'(0));
            exp_q.delete();
        end
        for (int i = 0; i < 6; i++) tick();
    endtask

    task automatic latency_test(input string name);
        res_t e;
        int n;
        e = model(23'h0ABCDE, 8'd2, 1'b1, 1'b0, 4'hA);
        seen_out = 1'b0;
        drive(23'h0ABCDE, 8'd2, 1'b1, 1'b0, 4'hA, e);
        seen_out = 1'b0;
        for (n = 1; n <= 20; n++) begin
            tick();
            if (seen_out) break;
        end
        check(name, 64'(n), 64'(LAT));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int oc;
        logic [SW-1:0] rc;
        logic [DW-1:0] rv;
        logic rd, ra;
        n_checks = 0; n_fail = 0; out_count = 0; stall_cnt = 0;
        held_v = 1'b0; seen_out = 1'b0; saw_block = 1'b0; rand_rdy = 1'b0;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        val = '0; count = '0; dir = 1'b0; arith = 1'b0; tag = '0; pend = '0;

        tbl[0]  = '{23'h000001, 8'd5,   1'b0, 1'b0, 23'h000020, 1'b0, 1'b0};
        tbl[1]  = '{23'h40000F, 8'd3,   1'b1, 1'b0, 23'h080001, 1'b1, 1'b0};
        tbl[2]  = '{23'h400000, 8'd200, 1'b1, 1'b1, 23'h7FFFFF, 1'b1, 1'b0};
        tbl[3]  = '{23'h400000, 8'd23,  1'b1, 1'b0, 23'h000000, 1'b1, 1'b0};
        tbl[4]  = '{23'h600000, 8'd1,   1'b0, 1'b0, 23'h400000, 1'b0, 1'b1};
        tbl[5]  = '{23'h123456, 8'd0,   1'b1, 1'b1, 23'h123456, 1'b0, 1'b0};
        tbl[6]  = '{23'h7FFFFF, 8'd0,   1'b0, 1'b0, 23'h7FFFFF, 1'b0, 1'b0};
        tbl[7]  = '{23'h400001, 8'd1,   1'b1, 1'b1, 23'h600000, 1'b1, 1'b0};
        tbl[8]  = '{23'h000003, 8'd22,  1'b0, 1'b0, 23'h400000, 1'b0, 1'b1};
        tbl[9]  = '{23'h00ABCD, 8'd23,  1'b0, 1'b0, 23'h000000, 1'b0, 1'b1};
        tbl[10] = '{23'h000000, 8'd255, 1'b1, 1'b1, 23'h000000, 1'b0, 1'b0};
        tbl[11] = '{23'h0000FF, 8'd8,   1'b1, 1'b0, 23'h000000, 1'b1, 1'b0};
        tbl[12] = '{23'h2AAAAA, 8'd4,   1'b0, 1'b1, 23'h2AAAA0, 1'b0, 1'b1};

        // Reset state
        @(negedge clk);
        @(negedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_outputs", 64'({val_o, sticky_o, ovf_o, tag_o}), 64'(0));
        check("rst_in_ready", 64'(in_ready), 64'(1));
        @(negedge clk);
        rst = 1'b0;

        // Table vectors, streamed back to back
        for (int i = 0; i < NV; i++) begin
            drive(tbl[i].v, tbl[i].c, tbl[i].d, tbl[i].a, TW'(i),
                  '{v: tbl[i].ev, s: tbl[i].es, o: tbl[i].eo, t: TW'(i)});
        end
        drain();

        // Unstalled latency
        latency_test("latency_idle");
        drain();

        // Backpressure: 8 ops, output stalled 6 cycles after the third
        saw_block = 1'b0;
        oc = out_count;
        for (int i = 0; i < 8; i++) begin
            rv = DW'(32'h10001 * (i + 1));
            drive(rv, SW'(i + 1), i[0], 1'b0, TW'(i), model(rv, SW'(i + 1), i[0], 1'b0, TW'(i)));
            if (i == 2) stall_cnt = 6;
        end
        drain();
        check("bp_in_ready_dropped", 64'(saw_block), 64'(1));
        check("bp_output_count", 64'(out_count - oc), 64'(8));

        // Reset with three ops in flight
        for (int i = 0; i < 3; i++) begin
            drive(23'h7FFFFF, 8'd1, 1'b1, 1'b1, TW'(i + 5), model(23'h7FFFFF, 8'd1, 1'b1, 1'b1, TW'(i + 5)));
        end
        #2;
        rst = 1'b1;
        #1;
        check("midrst_out_valid", 64'(out_valid), 64'(0));
        check("midrst_outputs", 64'({val_o, sticky_o, ovf_o, tag_o}), 64'(0));
        check("midrst_in_ready", 64'(in_ready), 64'(1));
        exp_q.delete();
        held_v = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        oc = out_count;
        for (int i = 0; i < 8; i++) tick();
        check("midrst_no_stale", 64'(out_count - oc), 64'(0));
        latency_test("latency_after_reset");
        drain();

        // Random stream with random backpressure
        rand_rdy = 1'b1;
        for (int i = 0; i < 60; i++) begin
            rv = DW'($urandom);
            rc = ($urandom_range(0, 7) == 0) ? SW'($urandom) : SW'($urandom_range(0, 24));
            rd = 1'($urandom_range(0, 1));
            ra = 1'($urandom_range(0, 1));
            drive(rv, rc, rd, ra, TW'(i), model(rv, rc, rd, ra, TW'(i)));
        end
        rand_rdy = 1'b0;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_fp_shift_pipe

`default_nettype wire
